// File: rtl/digital_timer_bcd_n.sv
// N-digit BCD timer: tick prescaler, up/down count, run/pause/preload control,
// terminal-count wrap or stop, and one registered active-low seven-segment byte per digit.
//
// state | meaning
// IDLE  | stopped after reset or preload, waiting for start
// RUN   | prescaler advancing, count steps on every tick
// PAUSE | stopped by stop, prescaler and count held
// DONE  | terminal count reached with wrap=0, count held
module digital_timer_bcd_n #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 25
) (
    input  logic                  clk_50MHz,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  dir,
    input  logic                  wrap,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [8*DIGITS-1:0]   seg,
    output logic                  running,
    output logic                  done,
    output logic                  terminal
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ALL_NINES = {DIGITS{4'h9}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]          state;
    logic [PW-1:0]       prescaler;
    logic                tick;
    logic                at_terminal;
    logic [CW-1:0]       count_step;
    logic [CW-1:0]       count_load;
    logic [8*DIGITS-1:0] seg_next;
    logic                step_carry;
    logic [3:0]          step_digit;
    logic [3:0]          load_digit;

    function automatic logic [7:0] seg_decode(input logic [3:0] code);
        logic [7:0] pattern;
        case (code)
            4'd0:    pattern = 8'hC0;
            4'd1:    pattern = 8'hF9;
            4'd2:    pattern = 8'hA4;
            4'd3:    pattern = 8'hB0;
            4'd4:    pattern = 8'h99;
            4'd5:    pattern = 8'h92;
            4'd6:    pattern = 8'h82;
            4'd7:    pattern = 8'hF8;
            4'd8:    pattern = 8'h80;
            4'd9:    pattern = 8'h90;
            default: pattern = 8'hFF;
        endcase
        return pattern;
    endfunction

    // Digit-serial +/-1: the carry/borrow ripples up only through digits at 9 (up) or 0 (down).
    always_comb begin
        count_step = count_bcd;
        step_carry = 1'b1;
        step_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            step_digit = count_bcd[4*i +: 4];
            if (step_carry) begin
                if (!dir) begin
                    if (step_digit == 4'd9) begin
                        count_step[4*i +: 4] = 4'd0;
                    end else begin
                        count_step[4*i +: 4] = step_digit + 4'd1;
                        step_carry = 1'b0;
                    end
                end else begin
                    if (step_digit == 4'd0) begin
                        count_step[4*i +: 4] = 4'd9;
                    end else begin
                        count_step[4*i +: 4] = step_digit - 4'd1;
                        step_carry = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        count_load = '0;
        seg_next   = '0;
        load_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            load_digit = load_value[4*i +: 4];
            count_load[4*i +: 4] = (load_digit > 4'd9) ? 4'd9 : load_digit;
            seg_next[8*i +: 8]   = seg_decode(count_bcd[4*i +: 4]);
        end
    end

    assign at_terminal = dir ? (count_bcd == '0) : (count_bcd == ALL_NINES);
    assign tick        = (state == RUN) && (prescaler == PRE_LAST);
    assign running     = (state == RUN);
    assign done        = (state == DONE);

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state     <= IDLE;
            prescaler <= '0;
            count_bcd <= '0;
            seg       <= {DIGITS{8'hC0}};
            terminal  <= 1'b0;
        end else begin
            terminal <= 1'b0;
            seg      <= seg_next;
            if (load) begin
                count_bcd <= count_load;
                prescaler <= '0;
                state     <= IDLE;
            end else if (stop) begin
                // stop also swallows a coincident tick and any start request
                if (state == RUN) begin
                    state <= PAUSE;
                end
            end else if (start && (state != RUN)) begin
                if (state != PAUSE) begin
                    prescaler <= '0;
                end
                if (state == DONE) begin
                    count_bcd <= dir ? ALL_NINES : '0;
                end
                state <= RUN;
            end else if (tick) begin
                prescaler <= '0;
                terminal  <= at_terminal;
                if (at_terminal && !wrap) begin
                    state <= DONE;
                end else begin
                    count_bcd <= count_step;
                end
            end else if (state == RUN) begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_digital_timer_bcd_n.sv
// Bench for digital_timer_bcd_n: a 2-digit/TICK_DIV=4 and a 4-digit/TICK_DIV=2 instance,
// each tracked every cycle by an integer-valued model, plus directed literal checks.
module tb_digital_timer_bcd_n;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk;
    logic r0, s0, p0, l0, d0, w0;
    logic [7:0]  lv0, c0;
    logic [15:0] sg0;
    logic run0, dn0, tm0;
    logic r1, s1, p1, l1, d1, w1;
    logic [15:0] lv1, c1;
    logic [31:0] sg1;
    logic run1, dn1, tm1;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   armed = 0;

    int   m_st[2];
    int   m_cnt[2];
    int   m_pre[2];
    int   m_segsrc[2];
    logic m_term[2];

    digital_timer_bcd_n #(.DIGITS(2), .TICK_DIV(4)) dut0 (
        .clk_50MHz(clk), .reset(r0), .start(s0), .stop(p0), .load(l0),
        .load_value(lv0), .dir(d0), .wrap(w0), .count_bcd(c0), .seg(sg0),
        .running(run0), .done(dn0), .terminal(tm0)
    );

    digital_timer_bcd_n #(.DIGITS(4), .TICK_DIV(2)) dut1 (
        .clk_50MHz(clk), .reset(r1), .start(s1), .stop(p1), .load(l1),
        .load_value(lv1), .dir(d1), .wrap(w1), .count_bcd(c1), .seg(sg1),
        .running(run1), .done(dn1), .terminal(tm1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] to_bcd(input int v, input int d);
        logic [63:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_digit(input int x);
        case (x)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] seg_of(input int v, input int d);
        logic [63:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < d; i++) begin
            r[8*i +: 8] = seg_digit(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int sanit(input logic [63:0] lv, input int d);
        int v, p;
        logic [3:0] dg;
        v = 0;
        p = 1;
        for (int i = 0; i < d; i++) begin
            dg = lv[4*i +: 4];
            if (dg > 4'd9) dg = 4'd9;
            v = v + int'(dg) * p;
            p = p * 10;
        end
        return v;
    endfunction

    // Model works on the plain integer count; BCD and segments are derived only for comparison.
    task automatic model_step(input int k, input int d, input int div, input logic rst,
                              input logic st, input logic sp, input logic ld,
                              input logic [63:0] lv, input logic dr, input logic wr);
        int modv, old;
        bit at_end;
        modv = 10 ** d;
        old  = m_cnt[k];
        if (rst) begin
            m_st[k] = M_IDLE; m_cnt[k] = 0; m_pre[k] = 0; m_term[k] = 1'b0; m_segsrc[k] = 0;
        end else begin
            m_segsrc[k] = old;
            m_term[k]   = 1'b0;
            if (ld) begin
                m_cnt[k] = sanit(lv, d); m_pre[k] = 0; m_st[k] = M_IDLE;
            end else if (sp) begin
                if (m_st[k] == M_RUN) m_st[k] = M_PAUSE;
            end else if (st && m_st[k] != M_RUN) begin
                if (m_st[k] == M_IDLE) m_pre[k] = 0;
                if (m_st[k] == M_DONE) begin
                    m_pre[k] = 0;
                    m_cnt[k] = dr ? modv - 1 : 0;
                end
                m_st[k] = M_RUN;
            end else if (m_st[k] == M_RUN) begin
                if (m_pre[k] == div - 1) begin
                    m_pre[k] = 0;
                    at_end = dr ? (old == 0) : (old == modv - 1);
                    m_term[k] = at_end;
                    if (at_end && !wr) m_st[k] = M_DONE;
                    else m_cnt[k] = dr ? (old + modv - 1) % modv : (old + 1) % modv;
                end else begin
                    m_pre[k] = m_pre[k] + 1;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic expired(input string nm, input int budget);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no event within %0d cycles (t=%0t)", nm, budget, $time);
    endtask

    task automatic wait_cnt(input int which, input logic [63:0] v, input bit want_eq,
                            input int budget, input string nm);
        bit ok;
        logic [63:0] cur;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            cur = (which == 0) ? {56'b0, c0} : {48'b0, c1};
            if ((cur == v) == want_eq) ok = 1;
        end
        if (!ok) expired(nm, budget);
    endtask

    task automatic wait_flag(input int sel, input int budget, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if ((sel == 0) ? tm0 : dn0) ok = 1;
        end
        if (!ok) expired(nm, budget);
    endtask

    always @(posedge clk) begin
        model_step(0, 2, 4, r0, s0, p0, l0, {56'b0, lv0}, d0, w0);
        model_step(1, 4, 2, r1, s1, p1, l1, {48'b0, lv1}, d1, w1);
    end

    always @(posedge clk) begin
        #1;
        if (armed) begin
            chk("m_count0", {56'b0, c0}, to_bcd(m_cnt[0], 2));
            chk("m_seg0", {48'b0, sg0}, seg_of(m_segsrc[0], 2));
            chk("m_running0", {63'b0, run0}, {63'b0, m_st[0] == M_RUN});
            chk("m_done0", {63'b0, dn0}, {63'b0, m_st[0] == M_DONE});
            chk("m_terminal0", {63'b0, tm0}, {63'b0, m_term[0]});
            chk("m_count1", {48'b0, c1}, to_bcd(m_cnt[1], 4));
            chk("m_seg1", {32'b0, sg1}, seg_of(m_segsrc[1], 4));
            chk("m_running1", {63'b0, run1}, {63'b0, m_st[1] == M_RUN});
            chk("m_done1", {63'b0, dn1}, {63'b0, m_st[1] == M_DONE});
            chk("m_terminal1", {63'b0, tm1}, {63'b0, m_term[1]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        r0 = 1; s0 = 0; p0 = 0; l0 = 0; d0 = 0; w0 = 0; lv0 = '0;
        r1 = 1; s1 = 0; p1 = 0; l1 = 0; d1 = 0; w1 = 0; lv1 = '0;
        @(negedge clk);
        armed = 1;
        @(negedge clk);
        chk("rst_count", {56'b0, c0}, 64'h00);
        chk("rst_seg", {48'b0, sg0}, 64'hC0C0);
        chk("rst_running", {63'b0, run0}, 64'd0);
        chk("rst_done", {63'b0, dn0}, 64'd0);
        chk("rst_terminal", {63'b0, tm0}, 64'd0);
        r0 = 0; r1 = 0;

        // 4-digit ripple: 0999 -> 1000, then reverse direction back to 0999
        l1 = 1; lv1 = 16'h0999; d1 = 0; w1 = 1;
        @(negedge clk);
        l1 = 0; s1 = 1;
        @(negedge clk);
        s1 = 0;
        wait_cnt(1, 64'h0999, 0, 10, "w4_change");
        chk("w4_carry", {48'b0, c1}, 64'h1000);
        @(negedge clk);
        chk("w4_seg", {32'b0, sg1}, 64'hF9C0C0C0);
        d1 = 1;
        wait_cnt(1, 64'h1000, 0, 10, "w4_back");
        chk("w4_borrow", {48'b0, c1}, 64'h0999);

        // up count with wrap
        d0 = 0; w0 = 1; s0 = 1;
        @(negedge clk);
        s0 = 0;
        repeat (3) @(negedge clk);
        chk("first_tick_early", {56'b0, c0}, 64'h00);
        @(negedge clk);
        chk("first_tick", {56'b0, c0}, 64'h01);
        wait_cnt(0, 64'h10, 1, 100, "reach_10");
        @(negedge clk);
        chk("seg_10", {48'b0, sg0}, 64'hF9C0);
        wait_cnt(0, 64'h99, 1, 400, "reach_99");
        wait_flag(0, 10, "wrap_terminal");
        chk("wrap_count", {56'b0, c0}, 64'h00);
        chk("wrap_running", {63'b0, run0}, 64'd1);
        @(negedge clk);
        chk("wrap_term_len", {63'b0, tm0}, 64'd0);

        // reset in the middle of a run
        repeat (6) @(negedge clk);
        r0 = 1;
        @(negedge clk);
        r0 = 0;
        chk("midrst_count", {56'b0, c0}, 64'h00);
        chk("midrst_seg", {48'b0, sg0}, 64'hC0C0);
        chk("midrst_running", {63'b0, run0}, 64'd0);

        // down from 03 to done
        l0 = 1; lv0 = 8'h03; d0 = 1; w0 = 0;
        @(negedge clk);
        l0 = 0; s0 = 1;
        @(negedge clk);
        s0 = 0;
        wait_flag(1, 40, "reach_done");
        chk("done_terminal", {63'b0, tm0}, 64'd1);
        chk("done_count", {56'b0, c0}, 64'h00);
        repeat (20) @(negedge clk);
        chk("done_hold", {56'b0, c0}, 64'h00);
        chk("done_still", {63'b0, dn0}, 64'd1);
        s0 = 1;
        @(negedge clk);
        s0 = 0;
        chk("restart_count", {56'b0, c0}, 64'h99);
        chk("restart_running", {63'b0, run0}, 64'd1);

        // pause with prescaler held at 2, resume
        wait_cnt(0, 64'h99, 0, 10, "pre_pause_tick");
        chk("pre_pause", {56'b0, c0}, 64'h98);
        @(negedge clk);
        @(negedge clk);
        p0 = 1;
        @(negedge clk);
        p0 = 0;
        repeat (50) @(negedge clk);
        chk("pause_count", {56'b0, c0}, 64'h98);
        chk("pause_running", {63'b0, run0}, 64'd0);
        s0 = 1;
        @(negedge clk);
        s0 = 0;
        chk("resume_e0", {56'b0, c0}, 64'h98);
        @(negedge clk);
        chk("resume_e1", {56'b0, c0}, 64'h98);
        @(negedge clk);
        chk("resume_e2", {56'b0, c0}, 64'h97);

        // load beats stop and start; 0x5C sanitises to 59
        l0 = 1; p0 = 1; s0 = 1; lv0 = 8'h5C;
        @(negedge clk);
        l0 = 0; p0 = 0; s0 = 0;
        chk("load_count", {56'b0, c0}, 64'h59);
        chk("load_running", {63'b0, run0}, 64'd0);
        chk("load_done", {63'b0, dn0}, 64'd0);
        @(negedge clk);
        chk("load_seg", {48'b0, sg0}, 64'h9290);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/digital_timer_bcd_n.md
# digital_timer_bcd_n

Parametrised N-digit BCD timer with built-in tick prescaler, up/down counting, run/pause control, preload and terminal-count handling, driving one registered seven-segment output byte per digit. It replaces the fixed two-digit 0–99 up-counter chain (divider, binary counter, binary-to-BCD converter, decoders). It sits directly between the board clock and the HEX displays. Counting is native BCD, so no binary-to-BCD stage is needed for any digit count.

## Interface
- DIGITS, default 2: number of BCD digits, range 1–8.
- TICK_DIV, default 25: board clocks per count tick, minimum 2.
- clk_50MHz input 1: board clock. All logic is on its rising edge.
- reset input 1: synchronous, active-high.
- start input 1: level. Run request.
- stop input 1: level. Pause request.
- load input 1: level. Preload request.
- load_value input 4*DIGITS: BCD preload value. Digit i is bits [4i+3:4i], and digit 0 is the ones digit.
- dir input 1: count direction. 0 counts up, 1 counts down. Sampled on every tick.
- wrap input 1: 1 wraps at the terminal count, 0 stops there. Sampled on every tick.
- count_bcd output 4*DIGITS: registered count value.
- seg output 8*DIGITS: registered segment bytes. Byte i is bits [8i+7:8i] and shows digit i.
- running output 1: high in state RUN.
- done output 1: high in state DONE.
- terminal output 1: one-clock pulse when a terminal count is reached.

## Operation
- FSM states are IDLE, RUN, PAUSE and DONE. Reset state is IDLE.
- Request priority, per clock: reset > load > stop > start > tick.
- load, in any state: count_bcd ← sanitised load_value, the prescaler clears, and the FSM goes to IDLE. Sanitising replaces any digit >9 with 9.
- start in IDLE or PAUSE goes to RUN. The prescaler clears on entry from IDLE and is kept on entry from PAUSE.
- stop in RUN goes to PAUSE. The prescaler holds.
- start in DONE goes to RUN and the count restarts from the opposite terminal: 0 when counting up, all-9s when counting down.
- Prescaler is 0..TICK_DIV-1. It advances only in RUN. tick = RUN and prescaler == TICK_DIV-1.
- On a tick, the count steps by ±1 in BCD with a digit-serial carry or borrow:
  - Up: a digit at 9 becomes 0 and carries.
  - Down: a digit at 0 becomes 9 and borrows.
- Terminal count is all-9s when counting up and all-0s when counting down.
- On a tick that starts from the terminal count:
  - wrap=1: the count rolls over (all-9s→0 or 0→all-9s), terminal pulses, and the FSM stays in RUN.
  - wrap=0: the count holds, terminal pulses, and the FSM goes to DONE.
- seg bit order is {dp,g,f,e,d,c,b,a}, active-low. dp is always 1 (off).
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Any other code shows FF (blank). This cannot occur after sanitising.

## Timing
- Values after reset: count_bcd=0, seg = all bytes C0, running=0, done=0, terminal=0, prescaler=0.
- count_bcd updates on the edge that ends the tick cycle.
- terminal rises on that same edge and lasts one clock.
- seg lags count_bcd by exactly one clock.
- running and done are registered from the FSM state and change on the same edge as the state.
- From IDLE with start asserted at edge E0, the first count change is at edge E0+TICK_DIV.
- load and stop in the same cycle: load wins, giving IDLE with the loaded value.
- stop and start in the same cycle: stop wins.
- A stop coinciding with a tick suppresses that tick: no count change and no terminal pulse.
- reset asserted mid-run returns all outputs to their reset values on the next edge. seg becomes C0 on that same edge.
- Changing dir while in RUN takes effect on the next tick. No prescaler restart.

## Test plan
- Reset (DIGITS=2, TICK_DIV=4): hold reset 2 clocks → count_bcd=00, seg=C0C0, running=0, done=0, terminal=0.
- Up count with wrap (TICK_DIV=4, wrap=1): start → count steps 00,01,…,09,10 every 4 clocks; seg shows F9C0 one clock after count=10. At 99→00, terminal pulses for 1 clock and running stays 1.
- Down to done: load 03, dir=1, wrap=0, start → count 02,01,00, then terminal pulses and done=1. Count holds at 00 for ≥20 more clocks. A further start → count 99, state RUN.
- Pause and resume: stop 2 clocks after a tick → count frozen and running=0 for 50 clocks. start → next change exactly 2 clocks later, since the prescaler was held.
- Load priority and sanitising: load=stop=start=1 with load_value=0x5C → count_bcd=59, state IDLE, running=0.
- Generic width (DIGITS=4, TICK_DIV=2): load 0999, dir=0, start → the tick gives 1000 with a 3-digit carry ripple. seg bytes become C0,C0,C0,F9, ones digit first.
